// File: rtl/ltl_violation_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : ltl_violation_reporter
//  Purpose  : Consumer of a monitor cluster's LTL verdict flags. Detects
//             rising violation flags, queues timestamped records in a small
//             FIFO drained over valid/ready, and maintains sticky flags, a
//             saturating violation counter and an interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module ltl_violation_reporter #(
    parameter int NUM_PROPS  = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [NUM_PROPS-1:0]          ltl_in,
    input  logic                          clear,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [NUM_PROPS-1:0]          evt_props,
    output logic [TS_WIDTH-1:0]           evt_timestamp,
    output logic                          evt_overflow,
    output logic [NUM_PROPS-1:0]          sticky,
    output logic [CNT_WIDTH-1:0]          viol_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          irq
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_ENT_W = NUM_PROPS + TS_WIDTH + 1;

    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]   c_FULL    = c_LVL_W'(FIFO_DEPTH);
    localparam logic [TS_WIDTH-1:0]  c_TS_ONE  = TS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    // Registered state
    logic [NUM_PROPS-1:0] r_ltl_q;
    logic [TS_WIDTH-1:0]  r_ts;
    logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_ovf_pend;
    logic [NUM_PROPS-1:0] r_sticky;
    logic [CNT_WIDTH-1:0] r_viol_count;
    logic                 r_irq;

    // Combinational control
    logic [NUM_PROPS-1:0] w_new;
    logic                 w_detect;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [NUM_PROPS-1:0] w_sticky_next;
    logic [c_ENT_W-1:0]   w_head;

    // Rising-edge detection, new records, and the push/pop/drop decision
    always_comb begin
        w_new         = run ? (ltl_in & ~r_ltl_q) : '0;
        w_detect      = (|w_new) && !clear;
        w_pop         = (r_level != '0) && evt_ready && !clear;
        w_full        = (r_level == c_FULL);
        // A full FIFO still accepts a record when the head leaves in the same cycle
        w_push        = w_detect && (!w_full || w_pop);
        w_drop        = w_detect && !w_push;
        w_sticky_next = clear ? '0 : (r_sticky | (w_detect ? w_new : '0));
        w_head        = r_mem[r_rd_ptr];
    end

    // Flag history and free-running timestamp; both advance only while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ltl_q <= '0;
            r_ts    <= '0;
        end else if (run) begin
            r_ltl_q <= ltl_in;
            r_ts    <= r_ts + c_TS_ONE;
        end
    end

    // Record FIFO: storage, pointers and occupancy, flushed by clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_new, r_ts, r_ovf_pend};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    // Pending-overflow marker: set by a drop, handed to the next pushed record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_pend <= 1'b0;
        end else if (clear || w_push) begin
            r_ovf_pend <= 1'b0;
        end else if (w_drop) begin
            r_ovf_pend <= 1'b1;
        end
    end

    // Sticky flags, saturating detection counter and interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sticky     <= '0;
            r_viol_count <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_sticky <= w_sticky_next;
            r_irq    <= |w_sticky_next;
            if (clear) begin
                r_viol_count <= '0;
            end else if (w_detect && (r_viol_count != '1)) begin
                r_viol_count <= r_viol_count + c_CNT_ONE;
            end
        end
    end

    assign evt_valid     = (r_level != '0);
    assign evt_props     = w_head[c_ENT_W-1 -: NUM_PROPS];
    assign evt_timestamp = w_head[TS_WIDTH:1];
    assign evt_overflow  = w_head[0];
    assign sticky        = r_sticky;
    assign viol_count    = r_viol_count;
    assign fifo_level    = r_level;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ltl_violation_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ltl_violation_reporter
//  Purpose  : Self-checking bench for ltl_violation_reporter; a queue-based
//             reference model predicts every output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ltl_violation_reporter;

    localparam int NP    = 9;
    localparam int DEPTH = 4;
    localparam int TSW   = 16;
    localparam int CW    = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [NP-1:0]   ltl_in;
    logic            clear;
    logic            evt_valid;
    logic            evt_ready;
    logic [NP-1:0]   evt_props;
    logic [TSW-1:0]  evt_timestamp;
    logic            evt_overflow;
    logic [NP-1:0]   sticky;
    logic [CW-1:0]   viol_count;
    logic [$clog2(DEPTH):0] fifo_level;
    logic            irq;

    ltl_violation_reporter #(
        .NUM_PROPS (NP),
        .FIFO_DEPTH(DEPTH),
        .TS_WIDTH  (TSW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .ltl_in       (ltl_in),
        .clear        (clear),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_props    (evt_props),
        .evt_timestamp(evt_timestamp),
        .evt_overflow (evt_overflow),
        .sticky       (sticky),
        .viol_count   (viol_count),
        .fifo_level   (fifo_level),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [NP-1:0] props;
        int            ts;
        bit            ovf;
    } rec_t;

    rec_t          q[$];
    logic [NP-1:0] m_prev;
    logic [NP-1:0] m_sticky;
    int            m_ts;
    int            m_cnt;
    bit            m_ovf;
    bit            m_irq;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev   = '0;
        m_sticky = '0;
        m_ts     = 0;
        m_cnt    = 0;
        m_ovf    = 0;
        m_irq    = 0;
    endtask

    task automatic compare_all();
        chk("valid",  {31'd0, evt_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("level",  32'(fifo_level), 32'(q.size()));
        chk("sticky", 32'(sticky), 32'(m_sticky));
        chk("count",  32'(viol_count), 32'(m_cnt));
        chk("irq",    {31'd0, irq}, {31'd0, m_irq});
        if (q.size() != 0) begin
            chk("props", 32'(evt_props), 32'(q[0].props));
            chk("ts",    32'(evt_timestamp), 32'(q[0].ts));
            chk("ovf",   {31'd0, evt_overflow}, {31'd0, q[0].ovf});
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge
    task automatic tick(input bit r, input logic [NP-1:0] d, input bit rdy, input bit clr);
        logic [NP-1:0] nw;
        bit            pop;
        rec_t          rec;
        run       = r;
        ltl_in    = d;
        evt_ready = rdy;
        clear     = clr;

        pop = (q.size() != 0) && rdy && !clr;
        nw  = r ? (d & ~m_prev) : '0;
        if (clr) begin
            q.delete();
            m_sticky = '0;
            m_cnt    = 0;
            m_ovf    = 0;
            m_irq    = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (nw != '0) begin
                if (q.size() < DEPTH) begin
                    rec.props = nw;
                    rec.ts    = m_ts;
                    rec.ovf   = m_ovf;
                    q.push_back(rec);
                    m_ovf = 0;
                end else begin
                    m_ovf = 1;
                end
                m_sticky = m_sticky | nw;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_irq = (m_sticky != '0);
        end
        if (r) begin
            m_prev = d;
            m_ts   = (m_ts + 1) % (1 << TSW);
        end

        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        run       = 1'b0;
        ltl_in    = '0;
        clear     = 1'b0;
        evt_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        chk("rst_props", 32'(evt_props), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(0, '0, 0, 0);

        // Held flag yields exactly one record stamped with ts=3
        repeat (3) tick(1, '0, 0, 0);
        tick(1, 9'h004, 0, 0);
        chk("t1_ts", 32'(evt_timestamp), 32'd3);
        repeat (4) tick(1, 9'h004, 0, 0);
        chk("t1_level", 32'(fifo_level), 32'd1);
        chk("t1_props", 32'(evt_props), 32'h004);
        chk("t1_cnt", 32'(viol_count), 32'd1);
        chk("t1_irq", {31'd0, irq}, 32'd1);

        // Two simultaneous rises share one record, visible one edge later
        tick(1, 9'h000, 1, 0);
        tick(1, 9'h101, 1, 0);
        chk("t2_valid", {31'd0, evt_valid}, 32'd1);
        chk("t2_props", 32'(evt_props), 32'h101);
        chk("t2_cnt", 32'(viol_count), 32'd2);
        tick(1, 9'h101, 1, 0);

        // Overflow: six rises into a depth-4 FIFO, then drain
        tick(1, '0, 0, 0);
        for (int k = 0; k < 6; k++) tick(1, NP'(1 << k), 0, 0);
        chk("t3_level", 32'(fifo_level), 32'd4);
        repeat (4) tick(1, '0, 1, 0);
        tick(1, 9'h010, 0, 0);
        chk("t3_ovf1", {31'd0, evt_overflow}, 32'd1);
        tick(1, '0, 1, 0);
        tick(1, 9'h020, 0, 0);
        chk("t3_ovf0", {31'd0, evt_overflow}, 32'd0);

        // Full FIFO with simultaneous pop and push keeps level at depth
        tick(1, '0, 1, 0);
        for (int k = 0; k < 4; k++) tick(1, NP'(1 << k), 0, 0);
        tick(1, 9'h100, 1, 0);
        chk("t4_level", 32'(fifo_level), 32'd4);
        repeat (5) tick(1, '0, 1, 0);

        // run=0 freezes everything; resuming with a high flag fires once
        for (int k = 0; k < 6; k++) tick(0, NP'($urandom), 0, 0);
        tick(1, 9'h1FF, 0, 0);
        chk("t5_level", 32'(fifo_level), 32'd1);
        tick(1, 9'h1FF, 0, 0);
        tick(1, '0, 1, 0);

        // Clear with queued records and a same-cycle detection
        tick(1, 9'h001, 0, 0);
        tick(1, 9'h002, 0, 0);
        tick(1, 9'h004, 0, 0);
        tick(1, 9'h00C, 0, 1);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_sticky", 32'(sticky), 32'd0);
        chk("t6_irq", {31'd0, irq}, 32'd0);
        tick(1, 9'h00C, 0, 0);
        chk("t6_nofire", 32'(fifo_level), 32'd0);
        tick(1, 9'h01C, 0, 0);

        // Asynchronous reset while a record is pending
        tick(1, 9'h03C, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, evt_valid}, 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NP-1:0] d;
            d = ltl_in;
            if ($urandom_range(0, 2) == 0) d = d ^ NP'(1 << $urandom_range(0, NP - 1));
            if ($urandom_range(0, 7) == 0) d = '0;
            tick($urandom_range(0, 9) != 0, d, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
